// File: rtl/compare_arbiter.sv
// rtl/compare_arbiter.sv - round-robin arbiter sharing one registered unsigned comparator
//
// Purpose:
//   N_REQ clients share a single eq/gt/lt comparator. In IDLE the arbiter grants one
//   requester (round-robin, starting after the last grant), latches its operand pair,
//   compares it in CMP and presents the result with the requester id in RESP until the
//   consumer accepts it.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid
//   req_a      operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      operand b, same packing
//   req_ready  one-hot accept strobe, only in IDLE
//   rsp_valid  result valid (RESP state)
//   rsp_ready  consumer accepts result
//   rsp_id     requester that owns the result
//   rsp_eq     a == b
//   rsp_gt     a >  b
//   rsp_lt     a <  b
//   busy       high whenever the FSM is not IDLE

module compare_arbiter #(
   parameter  int N_REQ = 4,
   parameter  int WIDTH = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic                   rsp_eq,
   output logic                   rsp_gt,
   output logic                   rsp_lt,
   output logic                   busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CMP,
      ST_RESP
   } state_t;

   state_t            state_q;
   logic [ID_W-1:0]   last_grant_q;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [ID_W-1:0]   id_q;
   logic              rsp_valid_q;
   logic [ID_W-1:0]   rsp_id_q;
   logic              eq_q;
   logic              gt_q;
   logic              lt_q;

   logic              grant_found_d;
   logic [ID_W-1:0]   grant_id_d;
   logic [ID_W-1:0]   scan_id;
   logic [WIDTH-1:0]  sel_a_d;
   logic [WIDTH-1:0]  sel_b_d;

   // Scan from farthest to nearest so the requester closest after the pointer
   // is the last one written and therefore wins.
   always_comb begin
      grant_found_d = 1'b0;
      grant_id_d    = '0;
      scan_id       = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         scan_id = ID_W'((int'(last_grant_q) + k) % N_REQ);
         if (req_valid[scan_id]) begin
            grant_found_d = 1'b1;
            grant_id_d    = scan_id;
         end
      end
   end

   always_comb begin
      sel_a_d = '0;
      sel_b_d = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_id_d == ID_W'(i)) begin
            sel_a_d = req_a[i*WIDTH +: WIDTH];
            sel_b_d = req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   // The accept strobe is combinational; gating with rst_n keeps it low while
   // reset is held even though the FSM already sits in IDLE.
   always_comb begin
      req_ready = '0;
      for (int i = 0; i < N_REQ; i++) begin
         req_ready[i] = rst_n && (state_q == ST_IDLE) && grant_found_d &&
                        (grant_id_d == ID_W'(i));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= ID_W'(N_REQ - 1);
         a_q          <= '0;
         b_q          <= '0;
         id_q         <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         eq_q         <= 1'b0;
         gt_q         <= 1'b0;
         lt_q         <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (grant_found_d) begin
                  a_q          <= sel_a_d;
                  b_q          <= sel_b_d;
                  id_q         <= grant_id_d;
                  last_grant_q <= grant_id_d;
                  state_q      <= ST_CMP;
               end
            end
            ST_CMP: begin
               eq_q        <= (a_q == b_q);
               gt_q        <= (a_q >  b_q);
               lt_q        <= (a_q <  b_q);
               rsp_id_q    <= id_q;
               rsp_valid_q <= 1'b1;
               state_q     <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  state_q     <= ST_IDLE;
               end
            end
            default: begin
               rsp_valid_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_eq    = eq_q;
   assign rsp_gt    = gt_q;
   assign rsp_lt    = lt_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_compare_arbiter.sv
// tb/tb_compare_arbiter.sv - self-checking bench for compare_arbiter

module tb_compare_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req_valid;
   logic [15:0] req_a;
   logic [15:0] req_b;
   logic [3:0]  req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_id;
   logic        rsp_eq;
   logic        rsp_gt;
   logic        rsp_lt;
   logic        busy;

   logic [3:0]  op_a [4];
   logic [3:0]  op_b [4];

   int n_checks = 0;
   int n_fail   = 0;
   int exp_last = 3;

   assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
   assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

   always #5 clk = ~clk;

   compare_arbiter #(.N_REQ(4), .WIDTH(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_eq    (rsp_eq),
      .rsp_gt    (rsp_gt),
      .rsp_lt    (rsp_lt),
      .busy      (busy)
   );

   // Round-robin reference: first requester after 'last', wrapping.
   function automatic int pick(input logic [3:0] v, input int last);
      int idx;
      for (int k = 1; k <= 4; k++) begin
         idx = (last + k) % 4;
         if (v[idx[1:0]]) return idx;
      end
      return -1;
   endfunction

   function automatic logic [3:0] onehot(input int g);
      if (g < 0) return 4'b0000;
      return 4'b0001 << g;
   endfunction

   task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
      op_a[i[1:0]] = a;
      op_b[i[1:0]] = b;
   endtask

   task automatic wait_idle;
      for (int k = 0; k < 8 && busy; k++) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wait_idle: busy=%b after cycle budget, expected 0", busy);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) set_op(i, 4'd0, 4'd0);
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (req_ready !== 4'b0000) begin
         n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready);
      end
      n_checks++;
      if ({rsp_valid, busy} !== 2'b00) begin
         n_fail++; $display("FAIL reset_valid_busy: got %b expected 00", {rsp_valid, busy});
      end
      n_checks++;
      if ({rsp_id, rsp_eq, rsp_gt, rsp_lt} !== 5'b0) begin
         n_fail++; $display("FAIL reset_rsp_fields: got %b expected 00000", {rsp_id, rsp_eq, rsp_gt, rsp_lt});
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL reset_first_grant: got %b expected 0001", req_ready);
      end
      @(negedge clk);
      req_valid = 4'h0;
      wait_idle();
      exp_last = 0;
   endtask

   task automatic test_single;
      @(negedge clk);
      set_op(2, 4'd5, 4'd9);
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 4'b0100) begin
         n_fail++; $display("FAIL single_grant: got %b expected 0100", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0000;
      set_op(2, 4'd9, 4'd5);
      #1;
      n_checks++;
      if ({busy, rsp_valid} !== 2'b10) begin
         n_fail++; $display("FAIL single_t1: busy/rsp_valid got %b expected 10", {busy, rsp_valid});
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt} !== {1'b1, 2'd2, 3'b001}) begin
         n_fail++; $display("FAIL single_rsp: got %b expected %b",
                            {rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt}, {1'b1, 2'd2, 3'b001});
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({busy, rsp_valid} !== 2'b00) begin
         n_fail++; $display("FAIL single_done: busy/rsp_valid got %b expected 00", {busy, rsp_valid});
      end
      exp_last = 2;
   endtask

   task automatic test_round_robin;
      int exp_g;
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = 4'h0;
      @(negedge clk);
      rst_n = 1'b1;
      exp_last = 3;
      for (int i = 0; i < 4; i++) set_op(i, 4'd7, 4'd7);
      rsp_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         exp_g = (exp_last + 1) % 4;
         @(negedge clk);
         req_valid = 4'hF;
         #1;
         n_checks++;
         if (req_ready !== onehot(exp_g)) begin
            n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", n, req_ready, onehot(exp_g));
         end
         exp_last = exp_g;
         @(negedge clk);
         #1;
         n_checks++;
         if (req_ready !== 4'b0000) begin
            n_fail++; $display("FAIL rr_cmp_quiet[%0d]: got %b expected 0000", n, req_ready);
         end
         @(negedge clk);
         #1;
         n_checks++;
         if ({req_ready, rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt} !== {4'b0000, 1'b1, 2'(exp_g), 3'b100}) begin
            n_fail++; $display("FAIL rr_rsp[%0d]: got %b expected %b", n,
                               {req_ready, rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt},
                               {4'b0000, 1'b1, 2'(exp_g), 3'b100});
         end
      end
      @(negedge clk);
      req_valid = 4'h0;
      wait_idle();
   endtask

   task automatic test_backpressure;
      @(negedge clk);
      set_op(1, 4'd15, 4'd0);
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++; $display("FAIL bp_grant: got %b expected 0010", req_ready);
      end
      exp_last = 1;
      @(negedge clk);
      req_valid = 4'hF;
      set_op(1, 4'd0, 4'd15);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if ({req_ready, rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt} !== {4'b0000, 1'b1, 2'd1, 3'b010}) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got %b expected %b", c,
                               {req_ready, rsp_valid, rsp_id, rsp_eq, rsp_gt, rsp_lt},
                               {4'b0000, 1'b1, 2'd1, 3'b010});
         end
      end
      @(negedge clk);
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if ({req_ready, rsp_valid} !== 5'b0000_1) begin
         n_fail++; $display("FAIL bp_rise: got %b expected 00001", {req_ready, rsp_valid});
      end
      @(negedge clk);
      #1;
      n_checks++;
      if ({req_ready, rsp_valid} !== {onehot(pick(4'hF, exp_last)), 1'b0}) begin
         n_fail++; $display("FAIL bp_after: got %b expected %b", {req_ready, rsp_valid},
                            {onehot(pick(4'hF, exp_last)), 1'b0});
      end
      exp_last = pick(4'hF, exp_last);
      @(negedge clk);
      req_valid = 4'h0;
      wait_idle();
   endtask

   task automatic test_wrap;
      @(negedge clk);
      req_valid = 4'b1000;
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 4'b1000) begin
         n_fail++; $display("FAIL wrap_setup: got %b expected 1000", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0000;
      wait_idle();
      @(negedge clk);
      req_valid = 4'b1010;
      #1;
      n_checks++;
      if (req_ready !== 4'b0010) begin
         n_fail++; $display("FAIL wrap_grant: got %b expected 0010", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0000;
      wait_idle();
      exp_last = 1;
   endtask

   task automatic test_reset_midop;
      @(negedge clk);
      set_op(2, 4'd3, 4'd3);
      req_valid = 4'b0100;
      rsp_ready = 1'b1;
      #1;
      n_checks++;
      if (req_ready !== 4'b0100) begin
         n_fail++; $display("FAIL midrst_grant: got %b expected 0100", req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++; $display("FAIL midrst_in_cmp: busy got %b expected 1", busy);
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({busy, rsp_valid} !== 2'b00) begin
         n_fail++; $display("FAIL midrst_assert: busy/rsp_valid got %b expected 00", {busy, rsp_valid});
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         n_checks++;
         if ({busy, rsp_valid} !== 2'b00) begin
            n_fail++; $display("FAIL midrst_no_rsp[%0d]: got %b expected 00", c, {busy, rsp_valid});
         end
      end
      @(negedge clk);
      req_valid = 4'hF;
      #1;
      n_checks++;
      if (req_ready !== 4'b0001) begin
         n_fail++; $display("FAIL midrst_ptr: got %b expected 0001", req_ready);
      end
      @(negedge clk);
      req_valid = 4'h0;
      wait_idle();
      exp_last = 0;
   endtask

   // Transaction-level reference: a pending compare becomes visible two cycles after
   // its accept and stays until the consumer takes it; new grants only with nothing pending.
   task automatic test_random;
      int         age;
      int         m_last;
      int         m_id;
      int         g;
      logic [3:0] m_a;
      logic [3:0] m_b;
      logic [3:0] v;
      logic [2:0] exp_cmp;
      age    = 0;
      m_last = exp_last;
      m_id   = 0;
      m_a    = '0;
      m_b    = '0;
      for (int c = 0; c < 1000; c++) begin
         @(negedge clk);
         v = 4'($urandom) & 4'($urandom);
         req_valid = v;
         for (int i = 0; i < 4; i++) begin
            op_a[i] = 4'($urandom);
            op_b[i] = ($urandom_range(0, 3) == 0) ? op_a[i] : 4'($urandom);
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         #1;
         g = (age == 0) ? pick(v, m_last) : -1;
         n_checks++;
         if (req_ready !== onehot(g)) begin
            n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, onehot(g));
         end
         n_checks++;
         if ({busy, rsp_valid} !== {age != 0, age == 2}) begin
            n_fail++; $display("FAIL rand_state[%0d]: busy/rsp_valid got %b expected %b", c,
                               {busy, rsp_valid}, {age != 0, age == 2});
         end
         if (age == 2) begin
            exp_cmp = {int'(m_a) == int'(m_b), int'(m_a) > int'(m_b), int'(m_a) < int'(m_b)};
            n_checks++;
            if ({rsp_id, rsp_eq, rsp_gt, rsp_lt} !== {2'(m_id), exp_cmp}) begin
               n_fail++; $display("FAIL rand_rsp[%0d]: got %b expected %b", c,
                                  {rsp_id, rsp_eq, rsp_gt, rsp_lt}, {2'(m_id), exp_cmp});
            end
            n_checks++;
            if (int'(rsp_eq) + int'(rsp_gt) + int'(rsp_lt) != 1) begin
               n_fail++; $display("FAIL rand_onehot[%0d]: eq/gt/lt got %b expected one-hot", c,
                                  {rsp_eq, rsp_gt, rsp_lt});
            end
         end
         if (g >= 0) begin
            m_a    = op_a[g[1:0]];
            m_b    = op_b[g[1:0]];
            m_id   = g;
            m_last = g;
            age    = 1;
         end else if (age == 1) begin
            age = 2;
         end else if (age == 2 && rsp_ready) begin
            age = 0;
         end
      end
      @(negedge clk);
      req_valid = 4'h0;
      rsp_ready = 1'b1;
      wait_idle();
      exp_last = m_last;
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_reset_midop();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1);
   end

endmodule
